// File: rtl/rf_pkg.sv
// Shared types and defaults for the register-file write-port arbiter.
package rf_pkg;
    localparam int RF_AW = 3;
    localparam int RF_DW = 16;
    localparam logic [7:0] CNT_MAX = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WRITE = 2'b01
    } state_t;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: on a tie the requester that was not granted last wins.
// Purely combinational; grants are mutually exclusive and only asserted with their request.
module rr_arb2 (
    input  logic req_a,
    input  logic req_b,
    input  logic last_grant,
    output logic gnt_a,
    output logic gnt_b,
    output logic any
);
    always_comb begin
        any   = req_a | req_b;
        gnt_a = req_a & (~req_b | last_grant);
        gnt_b = req_b & (~req_a | ~last_grant);
    end
endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the register file write port between A and B, issuing at most one write per step tick.
// Strobes are valid the cycle after step is sampled; requesters hold req/addr/data until ack.
module rf_write_arbiter
    import rf_pkg::*;
#(
    parameter int DW         = RF_DW,
    parameter int AW         = RF_AW,
    parameter int PROTECT_R0 = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          step,
    input  logic          req_a,
    input  logic          req_b,
    input  logic [AW-1:0] addr_a,
    input  logic [AW-1:0] addr_b,
    input  logic [DW-1:0] data_a,
    input  logic [DW-1:0] data_b,
    output logic          ack_a,
    output logic          ack_b,
    output logic          w_en,
    output logic [AW-1:0] w_adr,
    output logic [DW-1:0] w_data,
    output logic          busy,
    output logic          err_r0,
    output logic          last_grant,
    output logic [7:0]    cnt_a,
    output logic [7:0]    cnt_b
);
    state_t        state_q, state_d;
    logic          w_en_q, w_en_d;
    logic          ack_a_q, ack_a_d;
    logic          ack_b_q, ack_b_d;
    logic          busy_q, busy_d;
    logic          err_r0_q, err_r0_d;
    logic          last_grant_q, last_grant_d;
    logic [AW-1:0] w_adr_q, w_adr_d;
    logic [DW-1:0] w_data_q, w_data_d;
    logic [7:0]    cnt_a_q, cnt_a_d;
    logic [7:0]    cnt_b_q, cnt_b_d;

    logic          gnt_a, gnt_b, any_req;
    logic [AW-1:0] sel_adr;
    logic          commit;

    rr_arb2 u_arb (
        .req_a      (req_a),
        .req_b      (req_b),
        .last_grant (last_grant_q),
        .gnt_a      (gnt_a),
        .gnt_b      (gnt_b),
        .any        (any_req)
    );

    // Everything the WRITE cycle shows (strobes, last_grant, counters) is decided at the grant edge.
    always_comb begin
        state_d      = state_q;
        w_en_d       = 1'b0;
        ack_a_d      = 1'b0;
        ack_b_d      = 1'b0;
        busy_d       = 1'b0;
        err_r0_d     = 1'b0;
        last_grant_d = last_grant_q;
        w_adr_d      = w_adr_q;
        w_data_d     = w_data_q;
        cnt_a_d      = cnt_a_q;
        cnt_b_d      = cnt_b_q;
        sel_adr      = gnt_b ? addr_b : addr_a;
        commit       = !((PROTECT_R0 != 0) && (sel_adr == '0));
        case (state_q)
            ST_IDLE: begin
                if (step && any_req) begin
                    state_d      = ST_WRITE;
                    busy_d       = 1'b1;
                    w_adr_d      = sel_adr;
                    w_data_d     = gnt_b ? data_b : data_a;
                    w_en_d       = commit;
                    err_r0_d     = ~commit;
                    ack_a_d      = gnt_a;
                    ack_b_d      = gnt_b;
                    last_grant_d = gnt_b;
                    if (commit && gnt_a && (cnt_a_q != CNT_MAX)) cnt_a_d = cnt_a_q + 8'd1;
                    if (commit && gnt_b && (cnt_b_q != CNT_MAX)) cnt_b_d = cnt_b_q + 8'd1;
                end
            end
            ST_WRITE: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            w_en_q       <= 1'b0;
            ack_a_q      <= 1'b0;
            ack_b_q      <= 1'b0;
            busy_q       <= 1'b0;
            err_r0_q     <= 1'b0;
            last_grant_q <= 1'b1;
            w_adr_q      <= '0;
            w_data_q     <= '0;
            cnt_a_q      <= 8'd0;
            cnt_b_q      <= 8'd0;
        end else begin
            state_q      <= state_d;
            w_en_q       <= w_en_d;
            ack_a_q      <= ack_a_d;
            ack_b_q      <= ack_b_d;
            busy_q       <= busy_d;
            err_r0_q     <= err_r0_d;
            last_grant_q <= last_grant_d;
            w_adr_q      <= w_adr_d;
            w_data_q     <= w_data_d;
            cnt_a_q      <= cnt_a_d;
            cnt_b_q      <= cnt_b_d;
        end
    end

    assign w_en       = w_en_q;
    assign ack_a      = ack_a_q;
    assign ack_b      = ack_b_q;
    assign busy       = busy_q;
    assign err_r0     = err_r0_q;
    assign last_grant = last_grant_q;
    assign w_adr      = w_adr_q;
    assign w_data     = w_data_q;
    assign cnt_a      = cnt_a_q;
    assign cnt_b      = cnt_b_q;
endmodule

// File: doc/rf_write_arbiter.md
# rf_write_arbiter

Write-port arbiter and sequencer for the 8-entry register file. It shares the register file's single write port between two requesters (A: ALU writeback, B: load/external path). It grants one write per `step` tick with round-robin fairness. It drives the write-address decoder's `write` input and the file's data input for exactly one clock per granted write.

## Interface
Parameters:
- `DW`, 16, register data width
- `AW`, 3, register address width (8 registers)
- `PROTECT_R0`, 0, when 1, writes to address 0 are acknowledged but never committed

Ports:
- `clk`  input  1  single system clock, rising-edge
- `reset`  input  1  asynchronous, active-high reset
- `step`  input  1  single-cycle enable tick; one write may be issued per tick
- `req_a` / `req_b`  input  1  write request from A / B
- `addr_a` / `addr_b`  input  AW  target register for A / B
- `data_a` / `data_b`  input  DW  write data for A / B
- `ack_a` / `ack_b`  output  1  one-cycle acknowledge to A / B
- `w_en`  output  1  write strobe to decoder `write` input
- `w_adr`  output  AW  register address to decoder select
- `w_data`  output  DW  data to register file
- `busy`  output  1  high while in WRITE state
- `err_r0`  output  1  one-cycle pulse when a protected R0 write is dropped
- `last_grant`  output  1  0 = A granted last, 1 = B granted last
- `cnt_a` / `cnt_b`  output  8  committed-write counters, saturating

## Operation
- States: IDLE, WRITE (2-bit encoding, packaged enum).
- IDLE:
  - If `step`=1 and at least one `req` is high, pick the winner.
  - If only one request is high, that requester wins.
  - If both are high, the winner is the requester not equal to `last_grant`.
  - Latch the winner's addr/data into output registers and go to WRITE.
  - Otherwise stay in IDLE. `step` with no request is a no-op.
- WRITE:
  - `w_en`=1, except when PROTECT_R0=1 and `w_adr`=0; then `w_en`=0 and `err_r0`=1.
  - The winner's `ack` is 1.
  - `last_grant` updates to the winner.
  - If the write committed, the winner's counter increments, saturating at 255.
  - Unconditionally return to IDLE.
- Handshake rules:
  - A requester holds `req`, `addr` and `data` stable until it sees `ack`.
  - It deasserts `req` in the cycle after `ack`.
  - If `req` is still high when sampled in IDLE, it is a new request.
- The losing requester keeps `req` asserted. It is served on the next accepted `step`, even when both requesters target the same address; writes are ordered, never merged.
- `step` arriving in WRITE is ignored, not queued.
- `req` dropping before grant: the requester is simply not considered. No error.

## Timing
- Reset (async, any state including WRITE): state=IDLE; `w_en`, `ack_a`, `ack_b`, `busy`, `err_r0` = 0; `w_adr`=0; `w_data`=0; `last_grant`=1 (so A wins the first tie); `cnt_a`=`cnt_b`=0.
- A write interrupted by reset is lost, and its `ack` is never given.
- Latency:
  - `step` and `req` sampled high at edge N.
  - `w_en`, `ack`, `busy`, `w_adr` and `w_data` are valid during cycle N+1.
  - They drop at edge N+2.
- Maximum throughput is one write per 2 cycles (back-to-back `step` yields at most one write per 2 cycles).
- All outputs are registered; there are no combinational paths from inputs to outputs.
- `w_adr`/`w_data` hold their last value in IDLE. They are qualified only by `w_en`.

## Structure
- Package `rf_pkg`:
  - state enum (IDLE, WRITE)
  - `RF_AW`=3, `RF_DW`=16 defaults
  - `CNT_MAX`=8'hFF
- Sub-module `rr_arb2`: combinational 2-way round-robin picker. Inputs `req_a`, `req_b`, `last_grant`; outputs `gnt_a`, `gnt_b`, `any`.
- Everything else (FSM, output registers, counters) lives in `rf_write_arbiter`.

## Test plan
- Single request: after reset, `req_a`=1, `addr_a`=5, `data_a`=16'h1234, `step` pulse at edge N -> cycle N+1: `w_en`=1, `w_adr`=5, `w_data`=16'h1234, `ack_a`=1, `cnt_a`=1, `last_grant`=0.
- Tie fairness: both requests held (A→addr 2, B→addr 2), four `step` pulses 3 cycles apart -> grants A, B, A, B in that order; `cnt_a`=2, `cnt_b`=2; `w_en` never set on two consecutive cycles.
- Step during WRITE: `step` high on both N and N+1 with both requests -> exactly one write at N+1; the second `step` is ignored; B is granted only on the next `step` sampled in IDLE.
- R0 protection with PROTECT_R0=1: `req_b`=1, `addr_b`=0 -> `ack_b`=1, `err_r0`=1, `w_en`=0, `cnt_b` unchanged.
- Saturation: 300 granted A writes -> `cnt_a`=255 and holds.
- Async reset mid-WRITE: assert `reset` during cycle N+1 -> `w_en`/`ack`/`busy` drop immediately (without waiting for a clock edge); counters=0; `last_grant`=1; after release, a tie grants A first.
